// File: rtl/board_level_data_physical_decoder.sv
// Receive-side 6b/8b symbol decoder: classifies input FIFO bytes, checks framing, and queues tokens.
// Optional macro DECODER_ERR_CNT_EN builds the saturating err_count; otherwise err_count is tied to 0.
module board_level_data_physical_decoder #(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             empty,
  output logic             rd,
  input  logic             valid,
  input  logic [7:0]       encoded_data,
  input  logic             full,
  output logic             wr,
  output logic             frame_start,
  output logic             frame_end,
  output logic             frame_abort,
  output logic [5:0]       raw_data,
  output logic             frame_active,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [AW+1:0] DEPTH_V = (AW+2)'(BUF_DEPTH);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t        state;
  logic          rd_pending;
  logic [8:0]    mem [BUF_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   occ;
  logic [8:0]    head;
  logic [8:0]    push_tok;
  logic          accept, push, pop, start_ev, end_ev;

  assign accept = valid & rd_pending;

  // Reads in flight are counted against free space so the queue never overflows.
  assign rd = rst_n & ~empty &
              (({1'b0, occ} + {{(AW+1){1'b0}}, rd_pending}) < DEPTH_V);

  always_comb begin
    push     = 1'b0;
    start_ev = 1'b0;
    end_ev   = 1'b0;
    push_tok = '0;
    if (accept) begin
      if (encoded_data == 8'h01) begin
        push     = 1'b1;
        start_ev = 1'b1;
        push_tok = {state == IN_FRAME, 2'b01, 6'h00};
      end else if (state == IN_FRAME) begin
        if (encoded_data == 8'h02) begin
          push     = 1'b1;
          end_ev   = 1'b1;
          push_tok = {3'b010, 6'h00};
        end else if (encoded_data[1:0] == 2'b11) begin
          push     = 1'b1;
          push_tok = {3'b000, encoded_data[7:2]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      frame_active <= 1'b0;
      frame_count  <= '0;
      rd_pending   <= 1'b0;
    end else begin
      rd_pending <= rd;
      case (state)
        IDLE: begin
          if (start_ev) begin
            state        <= IN_FRAME;
            frame_active <= 1'b1;
            frame_count  <= frame_count + CNT_W'(1);
          end
        end
        IN_FRAME: begin
          if (start_ev) begin
            frame_count <= frame_count + CNT_W'(1);
          end else if (end_ev) begin
            state        <= IDLE;
            frame_active <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          frame_active <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_tok;
  end

  assign head        = mem[rptr];
  assign wr          = (occ != '0) & ~full;
  assign pop         = wr;
  assign frame_start = wr & head[6];
  assign frame_end   = wr & head[7];
  assign frame_abort = wr & head[8];
  assign raw_data    = wr ? head[5:0] : 6'h00;

`ifdef DECODER_ERR_CNT_EN
  logic err_ev;

  // Errors: anything but START/FILL while idle; START or BAD inside a frame.
  assign err_ev = accept & (
      (state == IDLE     && encoded_data != 8'h00 && encoded_data != 8'h01) ||
      (state == IN_FRAME && (encoded_data == 8'h01 ||
                             (encoded_data != 8'h00 && encoded_data != 8'h02 &&
                              encoded_data[1:0] != 2'b11))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_ev && (err_count != '1)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_board_level_data_physical_decoder.sv
// Bench for board_level_data_physical_decoder: input/output FIFO models plus a symbol-level reference model.
module tb_board_level_data_physical_decoder;

  localparam int unsigned BUF_DEPTH = 4;
  localparam int unsigned CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             empty;
  logic             rd;
  logic             valid;
  logic [7:0]       encoded_data;
  logic             full;
  logic             wr;
  logic             frame_start;
  logic             frame_end;
  logic             frame_abort;
  logic [5:0]       raw_data;
  logic             frame_active;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] err_count;

  board_level_data_physical_decoder #(
    .BUF_DEPTH(BUF_DEPTH),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .empty       (empty),
    .rd          (rd),
    .valid       (valid),
    .encoded_data(encoded_data),
    .full        (full),
    .wr          (wr),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_abort (frame_abort),
    .raw_data    (raw_data),
    .frame_active(frame_active),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Input FIFO contents, byte in flight, and reference model state.
  logic [7:0] src[$];
  bit         pend_valid;
  logic [7:0] pend_byte;
  int         full_mode;
  logic [8:0] exp_q[$];
  bit         m_in_frame;
  int         m_frames;
  int         m_err;
  int         rd_cnt;
  int         wr_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_err();
`ifdef DECODER_ERR_CNT_EN
    return m_err;
`else
    return 0;
`endif
  endfunction

  // Symbol-level rules: token = {abort, end, start, payload}.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h00) return;
    if (b == 8'h01) begin
      exp_q.push_back({m_in_frame, 2'b01, 6'h00});
      m_frames++;
      if (m_in_frame) m_err++;
      m_in_frame = 1'b1;
    end else if (!m_in_frame) begin
      m_err++;
    end else if (b == 8'h02) begin
      exp_q.push_back(9'b010_000000);
      m_in_frame = 1'b0;
    end else if (b[1:0] == 2'b11) begin
      exp_q.push_back({3'b000, b[7:2]});
    end else begin
      m_err++;
    end
  endtask

  task automatic cycle();
    logic [8:0] tok;
    @(negedge clk);
    valid        = pend_valid;
    encoded_data = pend_valid ? pend_byte : 8'($urandom);
    if (pend_valid) model_byte(pend_byte);
    pend_valid = 1'b0;
    empty = (src.size() == 0);
    full  = (full_mode == 1) ? 1'b1 : (full_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
    #1;
    tok = {frame_abort, frame_end, frame_start, raw_data};
    if (rd) begin
      rd_cnt++;
      check("rd_while_empty", 32'(empty), 32'd0);
      if (src.size() > 0) begin
        pend_valid = 1'b1;
        pend_byte  = src.pop_front();
      end
    end
    if (wr) begin
      wr_cnt++;
      if (exp_q.size() > 0) check("token", 32'(tok), 32'(exp_q.pop_front()));
      else check("unexpected_token", 32'(tok), 32'h1ff);
    end else begin
      check("token_idle_zero", 32'(tok), 32'd0);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src.size() > 0 || pend_valid || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
    exp_q.delete();
    repeat (3) cycle();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    empty = 1'b1;
    full  = 1'b0;
    encoded_data = 8'h00;
    src.delete();
    exp_q.delete();
    pend_valid = 1'b0;
    m_in_frame = 1'b0;
    m_frames = 0;
    m_err = 0;
    full_mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_count"}, 32'(frame_count), 32'(m_frames % (1 << CNT_W)));
    check({tag, "_err_count"},   32'(err_count),   32'(exp_err()));
  endtask

  initial begin
    rst_n = 1'b0;
    apply_reset();
    #1;
    check("reset_rd", 32'(rd), 32'd0);
    check("reset_outputs", 32'({wr, frame_start, frame_end, frame_abort, raw_data, frame_active}), 32'd0);
    check("reset_frame_count", 32'(frame_count), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);

    // Basic frame
    src = '{8'h01, 8'h0F, 8'h83, 8'h02};
    wr_cnt = 0;
    drain(50);
    check("basic_wr_count", 32'(wr_cnt), 32'd4);
    check("basic_frame_count", 32'(frame_count), 32'd1);
    check("basic_err_count", 32'(err_count), 32'd0);
    check("basic_frame_active", 32'(frame_active), 32'd0);

    // Filler and stray symbols in IDLE
    apply_reset();
    src = '{8'h00, 8'h07, 8'h02};
    wr_cnt = 0;
    drain(50);
    check("stray_wr_count", 32'(wr_cnt), 32'd0);
`ifdef DECODER_ERR_CNT_EN
    check("stray_err_count", 32'(err_count), 32'd2);
`else
    check("stray_err_count", 32'(err_count), 32'd0);
`endif

    // Restart inside a frame
    apply_reset();
    src = '{8'h01, 8'h13, 8'h01, 8'h02};
    wr_cnt = 0;
    drain(50);
    check("restart_wr_count", 32'(wr_cnt), 32'd4);
    check("restart_frame_count", 32'(frame_count), 32'd2);
    check_counts("restart");

    // BAD symbol inside a frame
    apply_reset();
    src = '{8'h01, 8'h05, 8'hFF, 8'h02};
    wr_cnt = 0;
    drain(50);
    check("bad_wr_count", 32'(wr_cnt), 32'd3);
    check_counts("bad");

    // Back-pressure: full held for 10 cycles at the start of a 20-byte frame
    apply_reset();
    src.push_back(8'h01);
    for (int i = 0; i < 18; i++) src.push_back({6'($urandom), 2'b11});
    src.push_back(8'h02);
    full_mode = 1;
    rd_cnt = 0;
    wr_cnt = 0;
    repeat (10) cycle();
    check("bp_rd_bounded", 32'(rd_cnt <= BUF_DEPTH), 32'd1);
    check("bp_rd_nonzero", 32'(rd_cnt > 0), 32'd1);
    check("bp_no_wr", 32'(wr_cnt), 32'd0);
    full_mode = 0;
    drain(200);
    check("bp_total_tokens", 32'(wr_cnt), 32'd20);
    check_counts("bp");

    // Randomized stream with random back-pressure
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      logic [7:0] b;
      case ($urandom_range(0, 9))
        0: b = 8'h01;
        1: b = 8'h02;
        2: b = 8'h00;
        3, 4: b = 8'($urandom);
        default: b = {6'($urandom), 2'b11};
      endcase
      src.push_back(b);
    end
    full_mode = 2;
    drain(3000);
    check_counts("random");
    check("random_frame_active", 32'(frame_active), 32'(m_in_frame));

    // Reset mid-frame: three tokens queued and a read in flight
    apply_reset();
    src = '{8'h01, 8'h07, 8'h0B, 8'h0F, 8'h13, 8'h17};
    full_mode = 1;
    repeat (4) cycle();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b1;
    encoded_data = 8'h01;
    empty = 1'b0;
    full = 1'b0;
    #1;
    check("midreset_rd", 32'(rd), 32'd0);
    check("midreset_outputs", 32'({wr, frame_start, frame_end, frame_abort, raw_data, frame_active}), 32'd0);
    check("midreset_frame_count", 32'(frame_count), 32'd0);
    check("midreset_err_count", 32'(err_count), 32'd0);
    src.delete();
    exp_q.delete();
    pend_valid = 1'b0;
    m_in_frame = 1'b0;
    m_frames = 0;
    m_err = 0;
    full_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1;
    encoded_data = 8'h01;
    empty = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    #1;
    check("stale_valid_frame_count", 32'(frame_count), 32'd0);
    check("stale_valid_wr", 32'(wr), 32'd0);
    check("stale_valid_frame_active", 32'(frame_active), 32'd0);
    src = '{8'h01};
    wr_cnt = 0;
    drain(50);
    check("post_reset_wr_count", 32'(wr_cnt), 32'd1);
    check("post_reset_frame_count", 32'(frame_count), 32'd1);
    check("post_reset_frame_active", 32'(frame_active), 32'd1);
    check("post_reset_err_count", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
